// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: FSM states,
// register map, STATUS layout and line-level helper.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_e;

    localparam int unsigned UART_SEL_BIT    = 15;
    localparam logic        UART_REG_DATA   = 1'b0;
    localparam logic        UART_REG_STATUS = 1'b1;

    localparam int unsigned STAT_BUSY    = 0;
    localparam int unsigned STAT_FULL    = 1;
    localparam int unsigned STAT_EMPTY   = 2;
    localparam int unsigned STAT_OVERRUN = 3;

    function automatic logic line_level(input uart_state_e st, input logic data_bit);
        case (st)
            START:   return 1'b0;
            DATA:    return data_bit;
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [15:0] pack_status(input logic busy, input logic full,
                                                input logic empty, input logic overrun);
        logic [15:0] s;
        s               = '0;
        s[STAT_BUSY]    = busy;
        s[STAT_FULL]    = full;
        s[STAT_EMPTY]   = empty;
        s[STAT_OVERRUN] = overrun;
        return s;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// TX byte queue. UART_TX_FIFO_EN selects a DEPTH-entry circular FIFO;
// otherwise a single holding register with a valid bit is used.
module uart_tx_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [7:0]               din,
    input  logic                     pop,
    output logic [7:0]               dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic do_push;
    logic do_pop;

`ifdef UART_TX_FIFO_EN
    localparam int unsigned PW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] cnt;

    assign full    = (cnt == CW'(DEPTH));
    assign empty   = (cnt == '0);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a push into a full queue is still taken.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];
    assign count   = cnt;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end
`else
    logic [7:0] hold;
    logic       valid;

    assign full    = valid;
    assign empty   = !valid;
    assign do_pop  = pop && valid;
    assign do_push = push && (!valid || do_pop);
    assign dout    = hold;
    assign count   = CW'(valid);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            valid <= 1'b0;
            hold  <= '0;
        end else begin
            if (do_push) begin
                valid <= 1'b1;
                hold  <= din;
            end else if (do_pop) begin
                valid <= 1'b0;
            end
        end
    end
`endif

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: DATA/STATUS register decode, overrun flag
// and serialiser FSM. Queue depth depends on UART_TX_FIFO_EN (see uart_tx_fifo).
module uart_tx_mmio
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 50000000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] addr,
    input  logic [15:0] data_in,
    output logic [15:0] data_out,
    input  logic        we,
    input  logic [1:0]  be,
    output logic        tx,
    output logic        tx_busy
);
    localparam int unsigned DIVISOR = CLK_HZ / BAUD;
    localparam int unsigned CNT_W   = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIVISOR - 1);

    logic sel;
    logic reg_idx;
    logic wr_data;
    logic wr_status;
    logic rd_status;

    assign sel       = addr[UART_SEL_BIT];
    assign reg_idx   = addr[1];
    assign wr_data   = sel && we && (reg_idx == UART_REG_DATA) && be[0];
    assign wr_status = sel && we && (reg_idx == UART_REG_STATUS);
    assign rd_status = sel && !we && (reg_idx == UART_REG_STATUS);

    logic unused_bits;
    assign unused_bits = ^{addr[14:2], addr[0], data_in[15:8], be[1]};

    uart_state_e state;
    uart_state_e state_next;
    logic [CNT_W-1:0] baud_cnt;
    logic [CNT_W-1:0] baud_next;
    logic [7:0]       shift;
    logic [7:0]       shift_next;
    logic [2:0]       bit_cnt;
    logic [2:0]       bit_next;
    logic             overrun;

    logic                          fifo_pop;
    logic [7:0]                    fifo_dout;
    logic                          fifo_full;
    logic                          fifo_empty;
    logic [$clog2(FIFO_DEPTH):0]   fifo_count;

    uart_tx_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .reset_n(reset_n),
        .push   (wr_data),
        .din    (data_in[7:0]),
        .pop    (fifo_pop),
        .dout   (fifo_dout),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .count  (fifo_count)
    );

    assign fifo_pop = (state == IDLE) && !fifo_empty;
    assign tx_busy  = (state != IDLE) || (fifo_count != '0);

    always_comb begin
        state_next = state;
        baud_next  = baud_cnt;
        shift_next = shift;
        bit_next   = bit_cnt;
        unique case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    state_next = START;
                    shift_next = fifo_dout;
                    bit_next   = '0;
                    baud_next  = CNT_LOAD;
                end
            end
            START: begin
                if (baud_cnt == '0) begin
                    state_next = DATA;
                    baud_next  = CNT_LOAD;
                end else begin
                    baud_next = baud_cnt - CNT_W'(1);
                end
            end
            DATA: begin
                if (baud_cnt == '0) begin
                    shift_next = {1'b0, shift[7:1]};
                    bit_next   = bit_cnt + 3'd1;
                    baud_next  = CNT_LOAD;
                    if (bit_cnt == 3'd7) state_next = STOP;
                end else begin
                    baud_next = baud_cnt - CNT_W'(1);
                end
            end
            STOP: begin
                if (baud_cnt == '0) begin
                    state_next = IDLE;
                    baud_next  = CNT_LOAD;
                end else begin
                    baud_next = baud_cnt - CNT_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // tx is registered from the next-state view so it changes on the same edge as the state.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= IDLE;
            baud_cnt <= '0;
            shift    <= '0;
            bit_cnt  <= '0;
            tx       <= 1'b1;
        end else begin
            state    <= state_next;
            baud_cnt <= baud_next;
            shift    <= shift_next;
            bit_cnt  <= bit_next;
            tx       <= line_level(state_next, shift_next[0]);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            overrun  <= 1'b0;
            data_out <= '0;
        end else begin
            if (wr_status) begin
                overrun <= 1'b0;
            end else if (wr_data && fifo_full && !fifo_pop) begin
                overrun <= 1'b1;
            end
            data_out <= rd_status ? pack_status(tx_busy, fifo_full, fifo_empty, overrun) : '0;
        end
    end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Scoreboard bench for uart_tx_mmio: a cycle-level timeline model predicts tx,
// tx_busy, data_out and the byte stream; monitors compare the DUT against it.
module tb_uart_tx_mmio;
    localparam int unsigned CLK_HZ     = 1000000;
    localparam int unsigned BAUD       = 62500;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam int D = CLK_HZ / BAUD;
`ifdef UART_TX_FIFO_EN
    localparam int CAP = FIFO_DEPTH;
`else
    localparam int CAP = 1;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        we = 1'b0;
    logic [1:0]  be = 2'b00;
    logic [15:0] addr = 16'h0;
    logic [15:0] data_in = 16'h0;
    logic [15:0] data_out;
    logic        tx;
    logic        tx_busy;

    uart_tx_mmio #(
        .CLK_HZ(CLK_HZ),
        .BAUD(BAUD),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .addr(addr),
        .data_in(data_in),
        .data_out(data_out),
        .we(we),
        .be(be),
        .tx(tx),
        .tx_busy(tx_busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int          c;
        logic        tx;
        logic        busy;
        logic [15:0] dout;
    } exp_t;

    exp_t       chk_q[$];
    logic [7:0] byte_q[$];

    // Reference model: pending bytes, cycle of the most recent pop, byte on the wire.
    logic [7:0]  m_q[$];
    int          m_last_pop = -1000000;
    logic [7:0]  m_cur = 8'h00;
    logic        m_ovr = 1'b0;
    logic [15:0] m_dout = 16'h0;
    bit          armed = 1'b0;

    function automatic bit m_active(input int c);
        return (c > m_last_pop) && (c <= m_last_pop + 10 * D);
    endfunction

    function automatic logic m_tx(input int c);
        int k;
        if (!m_active(c)) return 1'b1;
        k = (c - m_last_pop - 1) / D;
        if (k == 0) return 1'b0;
        if (k <= 8) return m_cur[k-1];
        return 1'b1;
    endfunction

    function automatic logic [15:0] m_status(input int c);
        logic [15:0] s;
        s    = 16'h0;
        s[0] = m_active(c) || (m_q.size() > 0);
        s[1] = (m_q.size() == CAP);
        s[2] = (m_q.size() == 0);
        s[3] = m_ovr;
        return s;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%04h expected 0x%04h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step(input logic rn, input logic w, input logic [1:0] b,
                        input logic [15:0] a, input logic [15:0] d);
        int          c;
        bit          pop_now;
        bit          push_req;
        bit          full_b;
        logic [15:0] s;
        @(posedge clk);
        #1;
        reset_n = rn;
        we      = w;
        be      = b;
        addr    = a;
        data_in = d;
        c = cyc;
        s = m_status(c);
        if (armed) chk_q.push_back('{c, m_tx(c), s[0], m_dout});
        m_dout = (rn && a[15] && !w && a[1]) ? s : 16'h0;
        if (!rn) begin
            m_q.delete();
            m_ovr      = 1'b0;
            m_last_pop = -1000000;
        end else begin
            pop_now  = !m_active(c) && (m_q.size() > 0);
            push_req = a[15] && w && !a[1] && b[0];
            full_b   = (m_q.size() == CAP);
            if (pop_now) begin
                m_cur      = m_q.pop_front();
                m_last_pop = c;
                byte_q.push_back(m_cur);
            end
            if (push_req) begin
                if (!full_b || pop_now) m_q.push_back(d[7:0]);
                else m_ovr = 1'b1;
            end
            if (a[15] && w && a[1]) m_ovr = 1'b0;
        end
        armed = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 2'b00, 16'h0000, 16'h0000);
    endtask

    task automatic wr_byte(input logic [7:0] v);
        step(1'b1, 1'b1, 2'b01, 16'h8000, {8'h00, v});
    endtask

    task automatic rd_status();
        step(1'b1, 1'b0, 2'b00, 16'h8002, 16'h0000);
    endtask

    task automatic drain();
        for (int i = 0; i < (CAP + 2) * 10 * D + 20; i++) begin
            if (m_q.size() == 0 && !m_active(cyc + 1)) break;
            idle(1);
        end
        idle(3);
    endtask

    // Per-cycle output monitor.
    always @(negedge clk) begin
        exp_t e;
        while (chk_q.size() > 0 && chk_q[0].c <= cyc) begin
            e = chk_q.pop_front();
            check("tx", {15'h0, tx}, {15'h0, e.tx});
            check("tx_busy", {15'h0, tx_busy}, {15'h0, e.busy});
            check("data_out", data_out, e.dout);
        end
    end

    // Frame decoder: samples mid-bit and compares each frame with the next expected byte.
    initial begin : decoder
        logic       prev;
        logic [9:0] bits;
        bit         aborted;
        logic [7:0] eb;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (reset_n === 1'b1 && prev === 1'b1 && tx === 1'b0) begin
                aborted = 1'b0;
                bits    = '0;
                for (int k = 0; k < 10; k++) begin
                    repeat ((k == 0) ? D / 2 : D) begin
                        @(negedge clk);
                        if (reset_n !== 1'b1) aborted = 1'b1;
                    end
                    if (aborted) break;
                    bits[k] = tx;
                end
                if (aborted) begin
                    if (byte_q.size() > 0) eb = byte_q.pop_front();
                end else if (byte_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL frame_unexpected: got frame 0x%03h expected none", bits);
                end else begin
                    eb = byte_q.pop_front();
                    check("frame", {6'h0, bits}, {6'h0, 1'b1, eb, 1'b0});
                end
            end
            prev = tx;
        end
    end

    initial begin
        int          r;
        logic [15:0] a;
        repeat (3) step(1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000);
        idle(2);
        rd_status();
        idle(2);

        wr_byte(8'h55);
        idle(10 * D + 4);

        step(1'b1, 1'b1, 2'b10, 16'h8000, 16'h00A5);
        idle(2);
        rd_status();
        idle(2);

        for (int i = 0; i < CAP + 2; i++) wr_byte(8'h10 + 8'(i));
        rd_status();
        step(1'b1, 1'b1, 2'b01, 16'h8002, 16'h0000);
        rd_status();
        drain();

        for (int i = 0; i < CAP + 1; i++) wr_byte(8'h30 + 8'(i));
        idle(2);
        while (cyc + 1 < m_last_pop + 10 * D + 1) idle(1);
        wr_byte(8'hC3);
        rd_status();
        drain();
        rd_status();
        idle(1);

        wr_byte(8'h96);
        idle(2);
        while (cyc + 1 < m_last_pop + 1 + 4 * D + D / 2) idle(1);
        step(1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000);
        step(1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000);
        idle(2);
        rd_status();
        idle(12 * D);

        for (int i = 0; i < 1200; i++) begin
            r = $urandom_range(0, 19);
            if (r < 3) begin
                a = {1'b1, 13'($urandom), 1'b0, 1'($urandom)};
                step(1'b1, 1'b1, 2'($urandom), a, 16'($urandom));
            end else if (r < 7) begin
                a = 16'($urandom);
                step(1'b1, 1'b0, 2'($urandom), a, 16'($urandom));
            end else if (r == 7) begin
                step(1'b1, 1'b1, 2'($urandom), 16'h8002 | 16'($urandom_range(0, 255) << 4), 16'h0);
            end else begin
                idle(1);
            end
        end
        drain();

        @(negedge clk);
        check("bytes_left", 16'(byte_q.size()), 16'h0);
        check("model_queue_left", 16'(m_q.size()), 16'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
